// File: rtl/vpu_pkg.sv
// vpu_pkg: shared VPU widths, issue-scheduler state type and delay clamp helper
package vpu_pkg;
   localparam int VPU_MAX_DELAY = 16;
   localparam int MAX_DELAY_LG2 = $clog2(VPU_MAX_DELAY + 1);
   localparam int ISSUE_TAG_W = 4;
   localparam int VPU_MAX_OUTSTANDING = 8;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} issue_state_t;
   function automatic logic [MAX_DELAY_LG2-1:0] clamp_delay(input logic [MAX_DELAY_LG2-1:0] d, input int max_d);
      return (d == '0) ? MAX_DELAY_LG2'(1) : (int'(d) > max_d) ? MAX_DELAY_LG2'(max_d) : d;
   endfunction
endpackage

// File: rtl/vpu_wb_resv_shift.sv
// vpu_wb_resv_shift: writeback-slot reservation shift register; index i means wb in i cycles
module vpu_wb_resv_shift
   import vpu_pkg::*;
#(
   parameter int DEPTH = VPU_MAX_DELAY,
   parameter int TAG_W = ISSUE_TAG_W,
   localparam int IW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_en,
   input  logic [IW-1:0]    set_idx,
   input  logic [TAG_W-1:0] set_tag,
   output logic             head_v,
   output logic [TAG_W-1:0] head_tag,
   output logic [DEPTH-1:0] peek
);
   logic [DEPTH-1:0] v, v_nxt;
   logic [TAG_W-1:0] tag [DEPTH];
   logic [TAG_W-1:0] tag_nxt [DEPTH];
   always_comb begin
      v_nxt = {1'b0, v[DEPTH-1:1]};
      for (int i = 0; i < DEPTH - 1; i++) tag_nxt[i] = tag[i+1];
      tag_nxt[DEPTH-1] = '0;
      if (set_en) begin
         v_nxt[set_idx] = 1'b1;
         tag_nxt[set_idx] = set_tag;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v <= '0;
         for (int i = 0; i < DEPTH; i++) tag[i] <= '0;
      end else begin
         v <= v_nxt;
         for (int i = 0; i < DEPTH; i++) tag[i] <= tag_nxt[i];
      end
   end
   assign head_v = v[0];
   assign head_tag = tag[0];
   assign peek = v;
endmodule

// File: rtl/vpu_issue_sched.sv
// vpu_issue_sched: issue scheduler with single shared writeback slot, outstanding limit and drain.
// Optional VPU_ISSUE_SCHED_PERF_EN adds saturating stall/conflict counters.
module vpu_issue_sched
   import vpu_pkg::*;
#(
   parameter int MAX_DELAY = VPU_MAX_DELAY,
   parameter int TAG_W = ISSUE_TAG_W,
   parameter int MAX_OUTSTANDING = VPU_MAX_OUTSTANDING,
   localparam int CW = $clog2(MAX_OUTSTANDING + 1),
   localparam int IW = $clog2(MAX_DELAY)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [MAX_DELAY_LG2-1:0] req_delay_i,
   input  logic [TAG_W-1:0]         req_tag_i,
   output logic                     start_o,
   output logic [MAX_DELAY_LG2-1:0] start_delay_o,
   output logic                     wb_valid_o,
   output logic [TAG_W-1:0]         wb_tag_o,
   input  logic                     flush_i,
   output logic                     flush_done_o,
`ifdef VPU_ISSUE_SCHED_PERF_EN
   output logic [31:0]              stall_cnt_o,
   output logic [31:0]              conflict_cnt_o,
`endif
   output logic                     idle_o,
   output logic [CW-1:0]            outstanding_o
);
   issue_state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [MAX_DELAY_LG2-1:0] d;
   logic [MAX_DELAY-1:0] peek;
   logic conflict, can_issue, fire;
   assign d = clamp_delay(req_delay_i, MAX_DELAY);
   // slot d is where an op issued now would land after the shift; d==MAX_DELAY is always free
   assign conflict = (int'(d) < MAX_DELAY) && peek[d[IW-1:0]];
   assign can_issue = (state != S_DRAIN) && !flush_i && (cnt < CW'(MAX_OUTSTANDING));
   assign req_ready_o = can_issue && !conflict;
   assign fire = req_valid_i && req_ready_o;
   assign start_o = fire;
   assign start_delay_o = d;
   assign cnt_nxt = cnt + CW'(fire) - CW'(wb_valid_o);
   assign idle_o = (cnt == '0);
   assign outstanding_o = cnt;
   assign flush_done_o = (state == S_DRAIN) && (cnt == '0);
   always_comb begin
      state_nxt = state;
      if (state == S_DRAIN) state_nxt = (cnt == '0) ? S_IDLE : S_DRAIN;
      else if (flush_i) state_nxt = S_DRAIN;
      else if (fire) state_nxt = S_RUN;
      else if (cnt_nxt == '0) state_nxt = S_IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt <= '0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
      end
   end
   vpu_wb_resv_shift #(.DEPTH(MAX_DELAY), .TAG_W(TAG_W)) u_resv (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (fire),
      .set_idx  (IW'(d - 1'b1)),
      .set_tag  (req_tag_i),
      .head_v   (wb_valid_o),
      .head_tag (wb_tag_o),
      .peek     (peek)
   );
`ifdef VPU_ISSUE_SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_o <= '0;
         conflict_cnt_o <= '0;
      end else begin
         if (req_valid_i && !req_ready_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
         if (req_valid_i && can_issue && conflict && conflict_cnt_o != '1) conflict_cnt_o <= conflict_cnt_o + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_vpu_issue_sched.sv
// tb_vpu_issue_sched: directed scenarios plus random traffic checked against an in-flight-op list model
module tb_vpu_issue_sched;
   logic clk = 1'b0;
   logic rst_n, req_valid_i, req_ready_o, start_o, wb_valid_o, flush_i, flush_done_o, idle_o;
   logic [4:0] req_delay_i, start_delay_o;
   logic [3:0] req_tag_i, wb_tag_o, outstanding_o;
`ifdef VPU_ISSUE_SCHED_PERF_EN
   logic [31:0] stall_cnt_o, conflict_cnt_o;
`endif
   always #5 clk = ~clk;

   vpu_issue_sched dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_delay_i   (req_delay_i),
      .req_tag_i     (req_tag_i),
      .start_o       (start_o),
      .start_delay_o (start_delay_o),
      .wb_valid_o    (wb_valid_o),
      .wb_tag_o      (wb_tag_o),
      .flush_i       (flush_i),
      .flush_done_o  (flush_done_o),
`ifdef VPU_ISSUE_SCHED_PERF_EN
      .stall_cnt_o   (stall_cnt_o),
      .conflict_cnt_o(conflict_cnt_o),
`endif
      .idle_o        (idle_o),
      .outstanding_o (outstanding_o)
   );

   int checks = 0, errors = 0;
   int now = 0;
   int q_done[$];
   logic [3:0] q_tag[$];
   bit drain = 0;
   int m_stall = 0, m_conf = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at cycle %0d", tag, got, exp, now);
      end
   endtask

   // one clock: drive, check against the op list at negedge, then retire/admit ops in the model
   task automatic cyc(input logic v, input logic [4:0] dl, input logic [3:0] tg, input logic fl,
                      input logic rn, output logic fired, output logic fd);
      int dc, cnt;
      bit conf, rdy, wbe;
      logic [3:0] wt;
      req_valid_i = v;
      req_delay_i = dl;
      req_tag_i = tg;
      flush_i = fl;
      rst_n = rn;
      dc = (dl == 0) ? 1 : (dl > 16) ? 16 : int'(dl);
      cnt = q_done.size();
      conf = 0;
      wbe = 0;
      wt = '0;
      foreach (q_done[i]) begin
         if (q_done[i] == now + dc) conf = 1;
         if (q_done[i] == now) begin
            wbe = 1;
            wt = q_tag[i];
         end
      end
      rdy = !drain && !fl && !conf && cnt < 8;
      fired = rn && v && rdy;
      fd = rn && drain && cnt == 0;
      @(negedge clk);
      if (rn) begin
         check("ready", 32'(req_ready_o), 32'(rdy));
         check("start", 32'(start_o), 32'(v && rdy));
         check("start_delay", 32'(start_delay_o), 32'(dc));
         check("wb_valid", 32'(wb_valid_o), 32'(wbe));
         if (wbe) check("wb_tag", 32'(wb_tag_o), 32'(wt));
         check("flush_done", 32'(flush_done_o), 32'(fd));
         check("idle", 32'(idle_o), 32'(cnt == 0));
         check("outstanding", 32'(outstanding_o), 32'(cnt));
`ifdef VPU_ISSUE_SCHED_PERF_EN
         check("stall_cnt", stall_cnt_o, 32'(m_stall));
         check("conflict_cnt", conflict_cnt_o, 32'(m_conf));
`endif
      end
      @(posedge clk);
      #1;
      if (!rn) begin
         q_done.delete();
         q_tag.delete();
         drain = 0;
         m_stall = 0;
         m_conf = 0;
      end else begin
         if (v && !rdy) m_stall++;
         if (v && conf && !drain && !fl && cnt < 8) m_conf++;
         if (fired) begin
            q_done.push_back(now + dc);
            q_tag.push_back(tg);
         end
         if (fd) drain = 0;
         else if (!drain && fl) drain = 1;
      end
      now++;
      for (int i = q_done.size() - 1; i >= 0; i--)
         if (q_done[i] < now) begin
            q_done.delete(i);
            q_tag.delete(i);
         end
   endtask

   logic f, fd, v, fl, hold, rn;
   logic [4:0] dl;
   logic [3:0] tg;

   task automatic idle_cycles(input int n);
      logic a, b;
      repeat (n) cyc(1'b0, 5'd1, 4'd0, 1'b0, 1'b1, a, b);
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid_i = 1'b0;
      req_delay_i = '0;
      req_tag_i = '0;
      flush_i = 1'b0;
      @(posedge clk);
      #1;
      repeat (2) cyc(1'b0, 5'd1, 4'd0, 1'b0, 1'b0, f, fd);
      idle_cycles(8);
      cyc(1'b1, 5'd5, 4'd3, 1'b0, 1'b1, f, fd);
      idle_cycles(8);
      cyc(1'b1, 5'd4, 4'd1, 1'b0, 1'b1, f, fd);
      repeat (2) cyc(1'b1, 5'd3, 4'd2, 1'b0, 1'b1, f, fd);
      idle_cycles(6);
      cyc(1'b1, 5'd8, 4'd1, 1'b0, 1'b1, f, fd);
      cyc(1'b1, 5'd2, 4'd2, 1'b0, 1'b1, f, fd);
      idle_cycles(10);
      for (int i = 0; i < 20; i++) cyc(1'b1, 5'd16, 4'(i), 1'b0, 1'b1, f, fd);
      idle_cycles(18);
      cyc(1'b1, 5'd12, 4'd7, 1'b0, 1'b1, f, fd);
      cyc(1'b1, 5'd10, 4'd8, 1'b0, 1'b1, f, fd);
      cyc(1'b1, 5'd6, 4'd9, 1'b0, 1'b1, f, fd);
      fd = 1'b0;
      for (int k = 0; k < 64 && !fd; k++) cyc(1'b1, 5'd5, 4'hA, 1'b1, 1'b1, f, fd);
      check("flush_timeout", 32'(fd), 32'd1);
      idle_cycles(2);
      cyc(1'b1, 5'd0, 4'd5, 1'b0, 1'b1, f, fd);
      cyc(1'b1, 5'd31, 4'd6, 1'b0, 1'b1, f, fd);
      idle_cycles(3);
      cyc(1'b1, 5'd6, 4'd1, 1'b0, 1'b1, f, fd);
      cyc(1'b1, 5'd7, 4'd2, 1'b0, 1'b1, f, fd);
      cyc(1'b0, 5'd1, 4'd0, 1'b0, 1'b0, f, fd);
      idle_cycles(10);
      hold = 1'b0;
      fl = 1'b0;
      v = 1'b0;
      dl = '0;
      tg = '0;
      for (int n = 0; n < 4000; n++) begin
         if (!hold) begin
            v = $urandom_range(0, 9) < 6;
            dl = 5'($urandom_range(0, 31));
            tg = 4'($urandom);
         end
         if (!fl && $urandom_range(0, 79) == 0) fl = 1'b1;
         rn = $urandom_range(0, 499) != 0;
         cyc(v, dl, tg, fl, rn, f, fd);
         hold = rn && v && !f;
         if (fd || !rn) fl = 1'b0;
      end
      idle_cycles(20);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
